// File: rtl/rv_prefetch_fetch.sv
// rv_prefetch_fetch
//   Instruction fetch unit. A Wishbone-classic master fetches words into a
//   prefetch FIFO, and each word is tagged with its PC. A redirect flushes
//   all prefetched and in-flight words and restarts fetch at a new address.
//   A bus error is pushed as a NOP entry with its error flag set. Fetching
//   then halts until the next redirect.
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   o_ib_cyc/o_ib_stb   Wishbone cycle/strobe (always equal, registered)
//   o_ib_adr            byte address of the word being fetched (registered)
//   i_ib_dat            instruction word from the slave
//   i_ib_ack/i_ib_err   transfer termination; err is ignored while ack is high
//   o_instr_valid       FIFO head holds an entry
//   o_instr/o_instr_pc  head instruction and its PC
//   o_instr_err         head is a bus-error entry
//   i_instr_ready       decode consumes the head when o_instr_valid is high
//   i_redirect          flush and restart fetch at i_redirect_pc (bits [1:0] ignored)
module rv_prefetch_fetch #(
  parameter int unsigned          PC_SIZE    = 32,
  parameter int unsigned          FIFO_DEPTH = 4,
  parameter logic [PC_SIZE-1:0]   RESET_PC   = {PC_SIZE{1'b0}}
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               o_ib_cyc,
  output logic               o_ib_stb,
  output logic [PC_SIZE-1:0] o_ib_adr,
  input  logic [31:0]        i_ib_dat,
  input  logic               i_ib_ack,
  input  logic               i_ib_err,
  output logic               o_instr_valid,
  output logic [31:0]        o_instr,
  output logic [PC_SIZE-1:0] o_instr_pc,
  output logic               o_instr_err,
  input  logic               i_instr_ready,
  input  logic               i_redirect,
  input  logic [PC_SIZE-1:0] i_redirect_pc
);

  localparam int unsigned          AW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned          CW         = AW + 1;
  localparam logic [CW-1:0]        DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [PC_SIZE-1:0]   PC_STEP    = PC_SIZE'(32'd4);
  localparam logic [PC_SIZE-1:0]   ALIGN_MASK = ~(PC_SIZE'(32'd3));
  localparam logic [31:0]          NOP_INSTR  = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t               state_r, state_next_s;
  logic                 stb_r, stb_next_s;
  logic [PC_SIZE-1:0]   adr_r, adr_next_s;
  logic [PC_SIZE-1:0]   fetch_pc_r, fetch_pc_next_s;
  logic                 halted_r, halted_next_s;

  logic [31:0]          data_mem_r [FIFO_DEPTH];
  logic [PC_SIZE-1:0]   pc_mem_r   [FIFO_DEPTH];
  logic                 err_mem_r  [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]        count_r, count_next_s;

  logic                 ack_s, err_s, term_s;
  logic                 push_s, pop_s, valid_s, launch_ok_s;
  logic [PC_SIZE-1:0]   redirect_pc_s;

  // Bus response qualification; err only counts when ack is low.
  assign ack_s         = stb_r & i_ib_ack;
  assign err_s         = stb_r & i_ib_err & ~i_ib_ack;
  assign term_s        = ack_s | err_s;
  assign redirect_pc_s = i_redirect_pc & ALIGN_MASK;

  // A response in REQ lands in the FIFO unless a redirect throws it away.
  assign push_s  = (state_r == ST_REQ) & term_s & ~i_redirect;
  assign valid_s = (count_r != {CW{1'b0}});
  assign pop_s   = valid_s & i_instr_ready & ~i_redirect;

  // FIFO occupancy after this cycle's push/pop/flush.
  always_comb begin
    count_next_s = count_r;
    if (i_redirect) begin
      count_next_s = {CW{1'b0}};
    end else begin
      count_next_s = count_r + CW'(push_s) - CW'(pop_s);
    end
  end

  // A new request may go out only if its word is guaranteed a slot.
  assign launch_ok_s = (count_next_s < DEPTH_C) & ~halted_r;

  // Fetch state register together with the registered bus outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      stb_r      <= 1'b0;
      adr_r      <= {PC_SIZE{1'b0}};
      fetch_pc_r <= RESET_PC;
      halted_r   <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      stb_r      <= stb_next_s;
      adr_r      <= adr_next_s;
      fetch_pc_r <= fetch_pc_next_s;
      halted_r   <= halted_next_s;
    end
  end

  // Next-state logic for the fetch FSM.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        // A redirect in IDLE only reloads fetch_pc; launch follows next cycle.
        if (!i_redirect && launch_ok_s) begin
          state_next_s = ST_REQ;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (i_redirect) begin
          // An unterminated request must be allowed to finish before reuse.
          state_next_s = term_s ? ST_IDLE : ST_DRAIN;
        end else if (ack_s) begin
          state_next_s = launch_ok_s ? ST_REQ : ST_IDLE;
        end else if (err_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_DRAIN: begin
        if (term_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered bus outputs.
  always_comb begin
    stb_next_s = (state_next_s != ST_IDLE);
    adr_next_s = adr_r;
    if ((state_r == ST_IDLE) && (state_next_s == ST_REQ)) begin
      adr_next_s = fetch_pc_r;
    end else if ((state_r == ST_REQ) && (state_next_s == ST_REQ) && ack_s) begin
      // Back-to-back fetch of the following word.
      adr_next_s = adr_r + PC_STEP;
    end else begin
      adr_next_s = adr_r;
    end
  end

  // Fetch address and halted flag updates.
  always_comb begin
    fetch_pc_next_s = fetch_pc_r;
    halted_next_s   = halted_r;
    if (i_redirect) begin
      fetch_pc_next_s = redirect_pc_s;
      halted_next_s   = 1'b0;
    end else if ((state_r == ST_REQ) && ack_s) begin
      fetch_pc_next_s = adr_r + PC_STEP;
      halted_next_s   = halted_r;
    end else if ((state_r == ST_REQ) && err_s) begin
      fetch_pc_next_s = fetch_pc_r;
      halted_next_s   = 1'b1;
    end else begin
      fetch_pc_next_s = fetch_pc_r;
      halted_next_s   = halted_r;
    end
  end

  // Prefetch FIFO pointers, count and entry storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (i_redirect) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      count_r <= count_next_s;
      if (push_s) begin
        data_mem_r[wr_ptr_r] <= ack_s ? i_ib_dat : NOP_INSTR;
        pc_mem_r[wr_ptr_r]   <= adr_r;
        err_mem_r[wr_ptr_r]  <= ~ack_s;
        wr_ptr_r             <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
    end
  end

  assign o_ib_cyc      = stb_r;
  assign o_ib_stb      = stb_r;
  assign o_ib_adr      = adr_r;
  assign o_instr_valid = valid_s;

  // Head outputs read straight from FIFO storage, zero when empty.
  always_comb begin
    if (valid_s) begin
      o_instr     = data_mem_r[rd_ptr_r];
      o_instr_pc  = pc_mem_r[rd_ptr_r];
      o_instr_err = err_mem_r[rd_ptr_r];
    end else begin
      o_instr     = 32'h0000_0000;
      o_instr_pc  = {PC_SIZE{1'b0}};
      o_instr_err = 1'b0;
    end
  end

endmodule

// File: tb/tb_rv_prefetch_fetch.sv
// Directed bench for rv_prefetch_fetch. Instance u_dut uses RESET_PC=0 with a
// slave that is either zero-wait (data = address) or driven by hand.
// Instance u_dut_hi uses RESET_PC=0xFFFF_FFF8 to exercise address wrap.
module tb_rv_prefetch_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ib_cyc, ib_stb;
  logic [31:0] ib_adr, ib_dat;
  logic        ib_ack, ib_err;
  logic        instr_valid, instr_err;
  logic [31:0] instr, instr_pc;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  logic        slv_auto = 1'b1;
  logic        man_ack = 1'b0;
  logic        man_err = 1'b0;
  logic [31:0] man_dat = 32'h0;

  logic        rst2_n = 1'b0;
  logic        cyc2, stb2, ack2, valid2, err2;
  logic [31:0] adr2, instr2, pc2;

  int n_vec = 0;
  int n_miss = 0;
  int ack_cnt = 0;
  int a0;

  always #5 clk = ~clk;

  assign ib_ack = slv_auto ? ib_stb : man_ack;
  assign ib_dat = slv_auto ? ib_adr : man_dat;
  assign ib_err = man_err;
  assign ack2   = stb2;

  always @(posedge clk) begin
    if (ib_cyc && ib_ack) ack_cnt <= ack_cnt + 1;
  end

  rv_prefetch_fetch #(.PC_SIZE(32), .FIFO_DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .o_ib_cyc(ib_cyc), .o_ib_stb(ib_stb), .o_ib_adr(ib_adr),
    .i_ib_dat(ib_dat), .i_ib_ack(ib_ack), .i_ib_err(ib_err),
    .o_instr_valid(instr_valid), .o_instr(instr), .o_instr_pc(instr_pc),
    .o_instr_err(instr_err), .i_instr_ready(instr_ready),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc)
  );

  rv_prefetch_fetch #(.PC_SIZE(32), .FIFO_DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_dut_hi (
    .clk(clk), .rst_n(rst2_n),
    .o_ib_cyc(cyc2), .o_ib_stb(stb2), .o_ib_adr(adr2),
    .i_ib_dat(adr2), .i_ib_ack(ack2), .i_ib_err(1'b0),
    .o_instr_valid(valid2), .o_instr(instr2), .o_instr_pc(pc2),
    .o_instr_err(err2), .i_instr_ready(1'b1),
    .i_redirect(1'b0), .i_redirect_pc(32'h0)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    check_val("rst_cyc",   {31'b0, ib_cyc},      32'h0);
    check_val("rst_stb",   {31'b0, ib_stb},      32'h0);
    check_val("rst_adr",   ib_adr,               32'h0);
    check_val("rst_valid", {31'b0, instr_valid}, 32'h0);
    check_val("rst_instr", instr,                32'h0);
    check_val("rst_pc",    instr_pc,             32'h0);
    check_val("rst_err",   {31'b0, instr_err},   32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    // Streaming with a zero-wait slave and decode always ready.
    tick();
    do_reset();
    slv_auto = 1'b1;
    instr_ready = 1'b1;
    tick();
    check_val("first_stb",   {31'b0, ib_stb},      32'h1);
    check_val("first_cyc",   {31'b0, ib_cyc},      32'h1);
    check_val("first_adr",   ib_adr,               32'h0);
    check_val("first_valid", {31'b0, instr_valid}, 32'h0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check_val("stream_valid", {31'b0, instr_valid}, 32'h1);
      check_val("stream_pc",    instr_pc, 32'(4 * k));
      check_val("stream_instr", instr,    32'(4 * k));
    end

    // Reset in the middle of a burst, then fill the FIFO with decode stalled.
    instr_ready = 1'b0;
    do_reset();
    a0 = ack_cnt;
    for (int k = 0; k < 5; k++) tick();
    check_val("full_acks", 32'(ack_cnt - a0), 32'd4);
    check_val("full_stb",  {31'b0, ib_stb},   32'h0);
    for (int k = 0; k < 3; k++) tick();
    check_val("full_hold_stb",  {31'b0, ib_stb},   32'h0);
    check_val("full_hold_acks", 32'(ack_cnt - a0), 32'd4);
    check_val("full_head_pc",   instr_pc,          32'h0);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check_val("relaunch_stb",  {31'b0, ib_stb}, 32'h1);
    check_val("relaunch_adr",  ib_adr,          32'h10);
    check_val("after_pop_pc",  instr_pc,        32'h4);
    tick();
    check_val("refull_stb",  {31'b0, ib_stb},   32'h0);
    check_val("refull_acks", 32'(ack_cnt - a0), 32'd5);

    // Slow slave: redirect during a wait state forces DRAIN.
    slv_auto = 1'b0;
    instr_ready = 1'b1;
    do_reset();
    tick();
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0102;
    tick();
    redirect = 1'b0;
    check_val("drain_stb", {31'b0, ib_stb}, 32'h1);
    check_val("drain_adr", ib_adr,          32'h0);
    man_ack = 1'b1;
    man_dat = 32'hDEAD_BEEF;
    tick();
    man_ack = 1'b0;
    check_val("drain_end_stb",   {31'b0, ib_stb},      32'h0);
    check_val("drain_end_valid", {31'b0, instr_valid}, 32'h0);
    tick();
    check_val("post_drain_stb", {31'b0, ib_stb}, 32'h1);
    check_val("post_drain_adr", ib_adr,          32'h100);
    man_ack = 1'b1;
    man_dat = 32'h1234_5678;
    tick();
    man_ack = 1'b0;
    check_val("redir_head_pc",    instr_pc,             32'h100);
    check_val("redir_head_instr", instr,                32'h1234_5678);
    check_val("redir_head_err",   {31'b0, instr_err},   32'h0);
    check_val("b2b_adr",          ib_adr,               32'h104);

    // Redirect coinciding with an ack: the word is dropped and no DRAIN occurs.
    man_ack = 1'b1;
    man_dat = 32'hBAD0_0001;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    man_ack = 1'b0;
    redirect = 1'b0;
    check_val("ackredir_valid", {31'b0, instr_valid}, 32'h0);
    check_val("ackredir_stb",   {31'b0, ib_stb},      32'h0);
    tick();
    check_val("ackredir_relaunch", {31'b0, ib_stb}, 32'h1);
    check_val("ackredir_adr",      ib_adr,          32'h200);
    man_ack = 1'b1;
    man_dat = 32'h0000_2000;
    tick();
    man_ack = 1'b0;
    check_val("ackredir_head_pc",    instr_pc, 32'h200);
    check_val("ackredir_head_instr", instr,    32'h2000);

    // Bus error halts fetch until a redirect.
    instr_ready = 1'b0;
    do_reset();
    tick();
    man_ack = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0020;
    tick();
    man_ack = 1'b0;
    redirect = 1'b0;
    tick();
    check_val("err_req_adr", ib_adr, 32'h20);
    man_err = 1'b1;
    tick();
    man_err = 1'b0;
    check_val("err_head_valid", {31'b0, instr_valid}, 32'h1);
    check_val("err_head_pc",    instr_pc,             32'h20);
    check_val("err_head_err",   {31'b0, instr_err},   32'h1);
    check_val("err_head_instr", instr,                32'h13);
    check_val("err_stb",        {31'b0, ib_stb},      32'h0);
    tick();
    tick();
    tick();
    check_val("halt_stb", {31'b0, ib_stb}, 32'h0);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0040;
    tick();
    redirect = 1'b0;
    tick();
    check_val("resume_stb",   {31'b0, ib_stb},      32'h1);
    check_val("resume_adr",   ib_adr,               32'h40);
    check_val("resume_valid", {31'b0, instr_valid}, 32'h0);
    man_ack = 1'b1;
    man_err = 1'b1;
    man_dat = 32'h0000_0055;
    tick();
    man_ack = 1'b0;
    man_err = 1'b0;
    check_val("ackerr_err",   {31'b0, instr_err}, 32'h0);
    check_val("ackerr_instr", instr,              32'h55);
    check_val("ackerr_pc",    instr_pc,           32'h40);

    // High reset address: fetch wraps through zero; reset mid-burst.
    rst2_n = 1'b1;
    tick();
    check_val("hi_first_adr", adr2, 32'hFFFF_FFF8);
    tick();
    check_val("hi_pc0", pc2, 32'hFFFF_FFF8);
    tick();
    check_val("hi_pc1", pc2, 32'hFFFF_FFFC);
    tick();
    check_val("hi_pc2", pc2, 32'h0);
    check_val("hi_instr2", instr2, 32'h0);
    tick();
    check_val("hi_pc3", pc2, 32'h4);
    rst2_n = 1'b0;
    tick();
    check_val("hi_rst_cyc",   {31'b0, cyc2},   32'h0);
    check_val("hi_rst_adr",   adr2,            32'h0);
    check_val("hi_rst_valid", {31'b0, valid2}, 32'h0);
    check_val("hi_rst_instr", instr2,          32'h0);
    check_val("hi_rst_pc",    pc2,             32'h0);
    check_val("hi_rst_err",   {31'b0, err2},   32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/rv_prefetch_fetch.md
# rv_prefetch_fetch

Parametrised instruction fetch unit for the RVCPU core family, replacing the single-register fetch (PC/PC_NEXT plus a one-cycle flush flag) with a Wishbone-classic instruction master feeding a configurable-depth prefetch FIFO. It sits between the instruction bus and the decode stage. It tags every instruction with its PC. It accepts branch/jump redirects that flush all prefetched and in-flight instructions. It reports bus errors in-band instead of stalling silently.

## Interface
Parameters:
- PC_SIZE, 32, width of all PC/address values (≥ 8)
- FIFO_DEPTH, 4, prefetch entries; power of two, ≥ 2
- RESET_PC, 0, fetch address after reset; bits [1:0] must be 0

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- o_ib_cyc  out  1  Wishbone cycle
- o_ib_stb  out  1  Wishbone strobe
- o_ib_adr  out  PC_SIZE  byte address of the word being fetched
- i_ib_dat  in  32  instruction word from the slave
- i_ib_ack  in  1  transfer acknowledge
- i_ib_err  in  1  transfer error; ignored when i_ib_ack is also high
- o_instr_valid  out  1  FIFO head holds a valid entry
- o_instr  out  32  instruction at the FIFO head
- o_instr_pc  out  PC_SIZE  PC of the FIFO head
- o_instr_err  out  1  FIFO head is a bus-error entry
- i_instr_ready  in  1  decode consumes the head this cycle when o_instr_valid is high
- i_redirect  in  1  flush and restart fetch
- i_redirect_pc  in  PC_SIZE  restart address; bits [1:0] ignored and treated as 0

## Operation
- The state machine has three states.
  - IDLE: no bus cycle is active.
  - REQ: cyc and stb are high and o_ib_adr is stable.
  - DRAIN: a request that is now stale stays open until the slave terminates it.
- There is at most one outstanding request. o_ib_cyc equals o_ib_stb in every state.
- fetch_pc register:
  - Holds the next address to request.
  - Advances by 4 on each accepted ack, modulo 2^PC_SIZE; 0xFFFFFFFC wraps to 0.
- Launch condition: the FIFO has a free slot after this cycle's push/pop, i.e. count_next < FIFO_DEPTH, and the halted flag is clear.
- IDLE → REQ when the launch condition is true. o_ib_adr is loaded with fetch_pc.
- REQ, ack received:
  - Push {i_ib_dat, o_ib_adr, err=0}.
  - If the launch condition still holds, stay in REQ with o_ib_adr = o_ib_adr+4 (back-to-back).
  - Otherwise go to IDLE.
- REQ, err received:
  - Push {32'h0000_0013, o_ib_adr, err=1}.
  - Set the halted flag and go to IDLE.
  - No further fetch happens until a redirect.
- Redirect:
  - Flush all FIFO entries (count=0) and load fetch_pc with i_redirect_pc.
  - Clear the halted flag.
  - If a request is open and not terminated this cycle, go to DRAIN.
  - Otherwise go to IDLE and relaunch next cycle.
- DRAIN:
  - stb and cyc stay high at the old address until ack or err. That response is discarded (no push).
  - Then go to IDLE.
  - A further redirect while in DRAIN only updates fetch_pc.
- Pop: the head is removed on o_instr_valid && i_instr_ready.
- FIFO: circular buffer with log2(FIFO_DEPTH)-bit pointers and a (log2+1)-bit count. Pointers wrap naturally.

## Timing
- Reset state: o_ib_cyc=o_ib_stb=0, o_ib_adr=0, o_instr_valid=0, o_instr=0, o_instr_pc=0, o_instr_err=0. fetch_pc=RESET_PC, FIFO empty, halted flag clear, state IDLE.
- First o_ib_stb: the cycle after rst_n rises, with o_ib_adr=RESET_PC.
- All bus outputs are registered. Head outputs are driven from the FIFO registers; there is no bus-to-decode combinational path.
- Fetch latency: data acked at edge n is the head at n+1 if the FIFO was empty.
- Throughput: with a slave that acks in the same cycle as stb, one instruction per cycle.
- Redirect at edge n with no open request: stb is high at n+1 with adr=i_redirect_pc. o_instr_valid is 0 from n+1 until the first new ack is pushed.
- Simultaneous events:
  - Redirect + ack in the same cycle: the ack is discarded and the redirect wins; no DRAIN.
  - Redirect + pop: the flush wins.
  - Push + pop when the FIFO is full: legal, count unchanged.
  - Push + pop when the FIFO is empty: the head is not bypassed; the push lands and valid rises next cycle.
- Full FIFO: stb deasserts after the current transfer and relaunches the cycle after a pop.
- Reset mid-transfer: cyc and stb drop at the next edge. Late acks are ignored because the state is IDLE.
- o_instr_pc[1:0] is always 0.

## Test plan
- Reset, zero-wait slave returning the address as data, ready=1 → stb at cycle 1 with adr=0. The core sees a valid entry every cycle from cycle 2, with pc 0,4,8,… and instr = pc.
- ready=0, FIFO_DEPTH=4 → exactly 4 acks accepted and stb low after the 4th. Raising ready for one cycle → one pop, then one new fetch of 0x10.
- Slave with 3-cycle ack latency, redirect to 0x0000_0102 in the second wait cycle → DRAIN holds adr=old until ack, and that ack is not pushed. The next stb has adr=0x100, and the first valid head has pc=0x100.
- Redirect asserted in the same cycle as ack → the acked word never appears. The next request goes to the redirect address with no DRAIN cycle.
- i_ib_err at adr 0x20 → the head is pc=0x20, err=1, instr=0x13, and there is no stb afterwards. A redirect to 0x40 resumes fetching at 0x40.
- RESET_PC=0xFFFF_FFF8, PC_SIZE=32 → fetch order 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4. Asserting rst_n=0 mid-burst → outputs return to their reset values at the next edge.
